// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I fetch stage. Owns the PC, fetches words over a req/ready
// handshake, holds each instruction for decode and discards fetches made stale by redirects.
`default_nettype none

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] pending_pc, pending_pc_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic        inst_valid_nxt;
  logic [31:0] redirect_word;

  assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

  // Request follows the state register only, so an async reset drops it at once.
  assign imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem_addr = fetch_addr;
  assign pc_plus4  = inst_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      pending_pc <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      pending_pc <= pending_pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= inst_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    pending_pc_nxt = pending_pc;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_valid_nxt = inst_valid;

    case (state)
      IDLE: begin
        if (redirect_valid) fetch_addr_nxt = redirect_word;
        state_nxt = FETCH;
      end

      FETCH: begin
        if (imem_ready) begin
          if (redirect_valid) begin
            fetch_addr_nxt = redirect_word;
          end else begin
            inst_nxt       = imem_rdata;
            inst_pc_nxt    = fetch_addr;
            inst_valid_nxt = 1'b1;
            fetch_addr_nxt = fetch_addr + 32'd4;
            state_nxt      = VALID;
          end
        end else if (redirect_valid) begin
          // The outstanding request must stay stable; park the target until it completes.
          pending_pc_nxt = redirect_word;
          state_nxt      = DISCARD;
        end
      end

      DISCARD: begin
        if (redirect_valid) pending_pc_nxt = redirect_word;
        if (imem_ready) begin
          fetch_addr_nxt = redirect_valid ? redirect_word : pending_pc;
          state_nxt      = FETCH;
        end
      end

      VALID: begin
        if (redirect_valid) begin
          inst_valid_nxt = 1'b0;
          inst_nxt       = NOP_INST;
          fetch_addr_nxt = redirect_word;
          state_nxt      = FETCH;
        end else if (!stall) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
`default_nettype none

module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [31:0] pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  ifetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ PAT;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL rst_inst got %h want %h", inst, NOP); end
    n_checks++; if (inst_pc !== 32'd0) begin n_fail++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid); end
    n_checks++; if (pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL rst_pc_plus4 got %h want 4", pc_plus4); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b want 1", imem_req); end
  endtask

  // Zero-wait memory: FETCH then VALID, repeating.
  task automatic test_zero_wait();
    logic [31:0] a;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_fail++; $display("FAIL zw_req[%0d] got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, a); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_off[%0d] got %b want 0", i, inst_valid); end
      tick();
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== a) begin n_fail++; $display("FAIL zw_on[%0d] got v=%b pc=%h want 1 %h", i, inst_valid, inst_pc, a); end
      n_checks++; if (inst !== (a ^ PAT)) begin n_fail++; $display("FAIL zw_inst[%0d] got %h want %h", i, inst, a ^ PAT); end
      n_checks++; if (pc_plus4 !== a + 32'd4) begin n_fail++; $display("FAIL zw_pc4[%0d] got %h want %h", i, pc_plus4, a + 32'd4); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_noreq[%0d] got %b want 0", i, imem_req); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    repeat (5) tick();
    stall = 1'b1;
    n_checks++; if (imem_addr !== 32'd8) begin n_fail++; $display("FAIL st_pre got %h want 8", imem_addr); end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd8 || inst !== (32'd8 ^ PAT)) begin n_fail++; $display("FAIL st_hold[%0d] got v=%b pc=%h inst=%h want 1 8 %h", k, inst_valid, inst_pc, inst, 32'd8 ^ PAT); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_noreq[%0d] got %b want 0", k, imem_req); end
      tick();
    end
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd8) begin n_fail++; $display("FAIL st_last got v=%b pc=%h want 1 8", inst_valid, inst_pc); end
    stall = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd12 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL st_next got req=%b addr=%h v=%b want 1 c 0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_delayed_redirect();
    do_reset();
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin n_fail++; $display("FAIL dl_hold[%0d] got req=%b addr=%h want 1 4", k, imem_req, imem_addr); end
      tick();
      redirect_valid = 1'b0;
    end
    imem_ready = 1'b1;
    n_checks++; if (imem_addr !== 32'd4) begin n_fail++; $display("FAIL dl_hold_rdy got %h want 4", imem_addr); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL dl_new got req=%b addr=%h v=%b want 1 100 0", imem_req, imem_addr, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== (32'h100 ^ PAT)) begin n_fail++; $display("FAIL dl_inst got v=%b pc=%h inst=%h want 1 100 %h", inst_valid, inst_pc, inst, 32'h100 ^ PAT); end
  endtask

  // Entered in VALID with inst_pc=0x100.
  task automatic test_redirect_over_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_fail++; $display("FAIL rs_kill got v=%b inst=%h want 0 %h", inst_valid, inst, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_addr got req=%b addr=%h want 1 200", imem_req, imem_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin n_fail++; $display("FAIL rs_inst got v=%b pc=%h want 1 200", inst_valid, inst_pc); end
  endtask

  // Entered in VALID with inst_pc=0x200.
  task automatic test_back_to_back();
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL bb_stale got req=%b addr=%h want 1 204", imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    n_checks++; if (imem_addr !== 32'h400 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL bb_latest got addr=%h v=%b want 400 0", imem_addr, inst_valid); end
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    imem_ready = 1'b1; redirect_pc = 32'h600;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h600) begin n_fail++; $display("FAIL bb_same_cycle got req=%b addr=%h want 1 600", imem_req, imem_addr); end
  endtask

  // Entered in FETCH with imem_ready=1.
  task automatic test_wrap_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin n_fail++; $display("FAIL wr_addr got addr=%h v=%b want fffffffc 0", imem_addr, inst_valid); end
    tick();
    n_checks++; if (inst_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL wr_pc4 got pc=%h pc4=%h want fffffffc 0", inst_pc, pc_plus4); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL wr_next got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL ma_addr got %h want 10", imem_addr); end
    tick();
    n_checks++; if (inst_pc !== 32'h10) begin n_fail++; $display("FAIL ma_pc got %h want 10", inst_pc); end
  endtask

  task automatic test_reset_in_discard();
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h700;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_fail++; $display("FAIL rd_pre got req=%b addr=%h want 1 14", imem_req, imem_addr); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL rd_async got req=%b addr=%h want 0 0", imem_req, imem_addr); end
    tick();
    rst = 1'b0; imem_ready = 1'b1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_idle got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL rd_restart got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin n_fail++; $display("FAIL rd_inst got v=%b pc=%h want 1 0", inst_valid, inst_pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_delayed_redirect();
    test_redirect_over_stall();
    test_back_to_back();
    test_wrap_misalign();
    test_reset_in_discard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the RV32I CPU. It owns the program counter and issues word requests to instruction memory over a req/ready handshake. It holds each returned instruction stable for the decode stage (immediate extender, control decoder) until decode consumes it. It accepts redirects (taken branch, jal, jalr) from the execute stage and discards in-flight fetches that a redirect makes stale.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- NOP_INST, 32'h0000_0013, value driven on `inst` when no instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch word address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory completes the request this cycle; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  execute stage requests a PC change.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0.
- stall  in  1  decode cannot consume the held instruction this cycle.
- inst  out  32  held instruction for decode.
- inst_pc  out  32  address of `inst`.
- inst_valid  out  1  `inst` is valid and awaiting consumption.
- pc_plus4  out  32  inst_pc + 4, combinational, modulo 2^32 (link value for jal/jalr).

## Operation
- Registers: fetch_addr (drives imem_addr), pending_pc, inst, inst_pc, inst_valid, and a 2-bit state.
- States: IDLE, FETCH, DISCARD, VALID.
- imem_req=1 in FETCH and DISCARD only.
- IDLE (one cycle after reset):
  - redirect_valid: fetch_addr<=redirect_pc.
  - Go to FETCH in either case.
- FETCH:
  - ready=1 and no redirect: inst<=imem_rdata, inst_pc<=fetch_addr, inst_valid<=1, fetch_addr<=fetch_addr+4, go to VALID.
  - ready=1 with redirect: drop rdata, fetch_addr<=redirect_pc, stay in FETCH.
  - ready=0 with redirect: pending_pc<=redirect_pc, go to DISCARD. fetch_addr is unchanged, because the request must stay stable.
  - ready=0 and no redirect: stay.
- DISCARD:
  - Keep the old request asserted.
  - A redirect overwrites pending_pc; the latest redirect wins, including one in the same cycle as ready.
  - ready=1: drop rdata, fetch_addr<=pending_pc (or redirect_pc if a redirect arrives that cycle), go to FETCH.
- VALID:
  - redirect_valid (priority over stall): inst_valid<=0, inst<=NOP_INST, fetch_addr<=redirect_pc, go to FETCH.
  - Else stall=0: instruction is consumed this cycle; inst_valid<=0, go to FETCH.
  - Else hold everything.
- fetch_addr increments wrap at 2^32 (0xFFFF_FFFC+4=0); no error flag.
- imem_ready outside FETCH/DISCARD is ignored.

## Timing
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - inst=NOP_INST, inst_pc=0, inst_valid=0, pc_plus4=4.
- Reset asserted mid-operation aborts any request immediately (imem_req drops asynchronously) and discards pending_pc.
- First imem_req is asserted in the 2nd cycle after rst deasserts.
- Zero-wait memory (ready in the first FETCH cycle): 2 cycles per instruction (FETCH, VALID). Each memory wait cycle adds 1.
- inst_valid rises the cycle after the ready handshake.
- Redirect-to-new-request latency is 1 cycle, plus the remaining wait of any stale request.
- An instruction is never presented twice, and none is skipped, except on a redirect.

## Test plan
- Reset, then zero-wait memory returning addr^32'hA5A5_0000:
  - inst_pc sequence is 0,4,8,12.
  - inst_valid toggles 1 cycle on / 1 off.
  - pc_plus4 = inst_pc+4.
- stall=1 for 3 cycles while VALID with inst_pc=8:
  - inst, inst_pc and inst_valid hold for 3 cycles.
  - imem_req=0 throughout.
  - The next fetch is 12.
- ready delayed 3 cycles on addr 4, redirect_pc=0x100 in the 1st wait cycle:
  - imem_addr stays 4 until ready.
  - Data from addr 4 is never presented.
  - The next request is 0x100.
- Redirect_pc=0x200 and stall=1 both asserted in VALID:
  - The redirect wins; inst_valid=0 next cycle.
  - The next request is 0x200.
- Two redirects (0x300, then 0x400) during DISCARD:
  - The request following the stale completion is 0x400.
- redirect_pc=0xFFFF_FFFC and redirect_pc=0x0000_0013:
  - Wrap case: the fetch after 0xFFFF_FFFC is 0x0000_0000.
  - Misaligned case: the fetch address is forced to 0x0000_0010.
  - Reset asserted mid-DISCARD: imem_req drops, then the fetch restarts at RESET_PC.
